// File: rtl/bias_pkg.sv
// Shared types and constants for the bias loader: FSM state encoding and widths.
package bias_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned ADDR_W       = 8;
  localparam int unsigned CNT_W        = 9;
  localparam int unsigned BIAS_MEM_LAT = 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    LOAD,
    HOLD,
    DONE
  } bias_ld_state_t;

endpackage

// File: rtl/bias_loader_if.sv
// Bundle of control, bias-memory and bias-buffer signals around the bias loader.
interface bias_loader_if;
  import bias_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  ch_count;
  logic              abort;
  logic              ch_next;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] bias_input;
  logic              bias_read;
  logic              bias_valid;
  logic [CNT_W-1:0]  ch_idx;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, ch_count, abort, ch_next, mem_rd_data,
    output mem_rd_en, mem_addr, bias_input, bias_read, bias_valid, ch_idx, busy, done
  );

  modport slave (
    output start, base_addr, ch_count, abort, ch_next, mem_rd_data,
    input  mem_rd_en, mem_addr, bias_input, bias_read, bias_valid, ch_idx, busy, done
  );

endinterface

// File: rtl/bias_loader.sv
// Fetches one bias per output channel from bias memory and loads it into the
// bias holding register, advancing one channel per consumer ch_next.
module bias_loader
  import bias_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  bias_loader_if.master bus
);

  bias_ld_state_t    state;
  bias_ld_state_t    state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  ch_idx_q;
  logic [DATA_W-1:0] bias_q;
  logic              last_ch;

  // count_q is never zero while in HOLD, so the decrement cannot underflow there
  assign last_ch = (ch_idx_q == CNT_W'(count_q - CNT_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // abort wins over start/ch_next in every non-idle state
  always_comb begin
    state_nx = state;
    if (state != IDLE && bus.abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nx = (bus.ch_count == '0) ? DONE : FETCH;
        FETCH:   state_nx = WAIT;
        WAIT:    state_nx = LOAD;
        LOAD:    state_nx = HOLD;
        HOLD:    if (bus.ch_next) state_nx = last_ch ? DONE : FETCH;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Layer parameters, channel index and the captured bias word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      count_q  <= '0;
      ch_idx_q <= '0;
      bias_q   <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        base_q   <= bus.base_addr;
        count_q  <= bus.ch_count;
        ch_idx_q <= '0;
      end
      if (state == WAIT && !bus.abort) begin
        bias_q <= bus.mem_rd_data;
      end
      if (state == HOLD && !bus.abort && bus.ch_next && !last_ch) begin
        ch_idx_q <= ch_idx_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    bus.mem_rd_en  = 1'b0;
    bus.mem_addr   = '0;
    bus.bias_read  = 1'b1;
    bus.bias_valid = 1'b0;
    bus.done       = 1'b0;
    bus.busy       = (state != IDLE);
    bus.bias_input = bias_q;
    bus.ch_idx     = ch_idx_q;
    case (state)
      FETCH: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = base_q + ADDR_W'(ch_idx_q);
      end
      LOAD:    bus.bias_read  = 1'b0;
      HOLD:    bus.bias_valid = 1'b1;
      DONE:    bus.done       = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bias_loader.sv
// Self-checking bench for bias_loader: directed scenarios plus randomized layers
// compared against a channel-list model of the expected memory/buffer traffic.
module tb_bias_loader;
  import bias_pkg::*;

  localparam int unsigned LAT = 2 + BIAS_MEM_LAT;
  localparam int unsigned OUT_W = 1 + ADDR_W + DATA_W + 1 + 1 + CNT_W + 1 + 1;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  bias_loader_if b();
  bias_loader dut (.clk(clk), .rst(rst), .bus(b));

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [256];

  // Memory returns data one cycle after the strobe; junk otherwise
  always @(posedge clk)
    b.mem_rd_data <= b.mem_rd_en ? mem[b.mem_addr] : DATA_W'($urandom);

  logic [ADDR_W-1:0] addr_q [$];
  logic [DATA_W-1:0] load_q [$];
  logic [DATA_W-1:0] hval_q [$];
  logic [CNT_W-1:0]  valid_q [$];
  int                lat_q [$];
  int                done_cnt;
  int                hold_cycles;
  bit                prev_valid;
  bit                clear_req = 1'b0;

  always @(negedge clk) begin
    if (clear_req) begin
      addr_q.delete(); load_q.delete(); hval_q.delete(); valid_q.delete();
      done_cnt = 0; hold_cycles = 0;
    end
    if (b.mem_rd_en) addr_q.push_back(b.mem_addr);
    if (!b.bias_read) load_q.push_back(b.bias_input);
    if (b.bias_valid && !prev_valid) begin
      valid_q.push_back(b.ch_idx);
      hval_q.push_back(b.bias_input);
    end
    if (b.bias_valid) hold_cycles++;
    if (b.done) done_cnt++;
    prev_valid = b.bias_valid;
  end

  function automatic logic [OUT_W-1:0] outs();
    return {b.mem_rd_en, b.mem_addr, b.bias_input, b.bias_read, b.bias_valid,
            b.ch_idx, b.busy, b.done};
  endfunction

  localparam logic [OUT_W-1:0] RESET_OUTS =
    {1'b0, ADDR_W'(0), DATA_W'(0), 1'b1, 1'b0, CNT_W'(0), 1'b0, 1'b0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    clear_req = 1'b1;
    @(negedge clk);
    #1;
    clear_req = 1'b0;
  endtask

  task automatic wait_valid(output int n, output bit to);
    n = 0; to = 1'b0;
    while (!b.bias_valid) begin
      if (n >= 40) begin to = 1'b1; return; end
      step(); n++;
    end
  endtask

  task automatic wait_idle(output bit to);
    int n = 0;
    to = 1'b0;
    while (b.busy) begin
      if (n >= 40) begin to = 1'b1; return; end
      step(); n++;
    end
  endtask

  // Drives one layer: start pulse, then ch_next 'gap' cycles after each bias_valid
  task automatic run_layer(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt,
                           input int gap, output bit to);
    int n;
    to = 1'b0;
    lat_q.delete();
    b.base_addr = base; b.ch_count = cnt; b.start = 1'b1;
    step();
    b.start = 1'b0;
    for (int i = 0; i < int'(cnt); i++) begin
      wait_valid(n, to);
      if (to) return;
      lat_q.push_back(n);
      repeat (gap) step();
      b.ch_next = 1'b1;
      step();
      b.ch_next = 1'b0;
    end
    wait_idle(to);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    b.start = 1'b0; b.abort = 1'b0; b.ch_next = 1'b0;
    b.base_addr = '0; b.ch_count = '0;
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (outs() !== RESET_OUTS) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected %h", outs(), RESET_OUTS);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    vectors++;
    if (outs() !== RESET_OUTS) begin
      miscompares++;
      $display("FAIL reset_idle_after_release: got %h expected %h", outs(), RESET_OUTS);
    end
  endtask

  task automatic test_basic();
    bit to;
    logic [ADDR_W-1:0] ea [3] = '{8'h10, 8'h11, 8'h12};
    logic [DATA_W-1:0] ed [3] = '{8'h11, 8'h12, 8'h13};
    for (int a = 0; a < 256; a++) mem[a] = DATA_W'(a + 1);
    clear_obs();
    run_layer(8'h10, 9'd3, 2, to);
    vectors++;
    if (to || addr_q.size() != 3 || load_q.size() != 3 || hval_q.size() != 3) begin
      miscompares++;
      $display("FAIL basic_counts: timeout=%0d rd=%0d loads=%0d holds=%0d required 0/3/3/3",
               to, addr_q.size(), load_q.size(), hval_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (addr_q[i] !== ea[i] || load_q[i] !== ed[i] || hval_q[i] !== ed[i]) begin
          miscompares++;
          $display("FAIL basic_ch%0d: addr=%h load=%h hold=%h required %h/%h/%h",
                   i, addr_q[i], load_q[i], hval_q[i], ea[i], ed[i], ed[i]);
        end
      end
    end
    vectors++;
    if (done_cnt != 1 || b.ch_idx !== 9'd2 || b.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: done_pulses=%0d ch_idx=%0d busy=%b required 1/2/0",
               done_cnt, b.ch_idx, b.busy);
    end
    foreach (lat_q[i]) begin
      vectors++;
      if (lat_q[i] != int'(LAT)) begin
        miscompares++;
        $display("FAIL basic_latency%0d: got %0d required %0d", i, lat_q[i], LAT);
      end
    end
  endtask

  task automatic test_zero_count();
    clear_obs();
    b.base_addr = 8'h55; b.ch_count = '0; b.start = 1'b1;
    step();
    b.start = 1'b0;
    vectors++;
    if (b.done !== 1'b1 || b.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_done_pulse: done=%b busy=%b required 1/1", b.done, b.busy);
    end
    step();
    vectors++;
    if (b.done !== 1'b0 || b.busy !== 1'b0 || addr_q.size() != 0 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL zero_after: done=%b busy=%b reads=%0d pulses=%0d required 0/0/0/1",
               b.done, b.busy, addr_q.size(), done_cnt);
    end
  endtask

  task automatic test_wrap();
    bit to;
    logic [ADDR_W-1:0] ea [3] = '{8'hFE, 8'hFF, 8'h00};
    for (int a = 0; a < 256; a++) mem[a] = DATA_W'($urandom);
    clear_obs();
    run_layer(8'hFE, 9'd3, 0, to);
    vectors++;
    if (to || addr_q.size() != 3 || load_q.size() != 3 || valid_q.size() != 3) begin
      miscompares++;
      $display("FAIL wrap_counts: timeout=%0d rd=%0d loads=%0d visits=%0d required 0/3/3/3",
               to, addr_q.size(), load_q.size(), valid_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (addr_q[i] !== ea[i] || load_q[i] !== mem[ea[i]] || valid_q[i] !== CNT_W'(i)) begin
          miscompares++;
          $display("FAIL wrap_ch%0d: addr=%h data=%h idx=%0d required %h/%h/%0d",
                   i, addr_q[i], load_q[i], valid_q[i], ea[i], mem[ea[i]], i);
        end
      end
    end
  endtask

  task automatic test_start_busy();
    bit to;
    for (int a = 0; a < 256; a++) mem[a] = DATA_W'($urandom);
    clear_obs();
    b.ch_next = 1'b1;
    b.base_addr = 8'h40; b.ch_count = 9'd3; b.start = 1'b1;
    step();
    b.base_addr = 8'h80; b.ch_count = 9'd5;
    repeat (6) step();
    b.start = 1'b0;
    wait_idle(to);
    b.ch_next = 1'b0;
    vectors++;
    if (to || hold_cycles != 3 || done_cnt != 1 || addr_q.size() != 3 || valid_q.size() != 3) begin
      miscompares++;
      $display("FAIL busy_counts: timeout=%0d holds=%0d pulses=%0d rd=%0d visits=%0d required 0/3/1/3/3",
               to, hold_cycles, done_cnt, addr_q.size(), valid_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (addr_q[i] !== ADDR_W'(8'h40 + i) || valid_q[i] !== CNT_W'(i)
            || hval_q[i] !== mem[8'h40 + i]) begin
          miscompares++;
          $display("FAIL busy_ch%0d: addr=%h idx=%0d data=%h required %h/%0d/%h",
                   i, addr_q[i], valid_q[i], hval_q[i], 8'h40 + i, i, mem[8'h40 + i]);
        end
      end
    end
    vectors++;
    if (b.ch_idx !== 9'd2) begin
      miscompares++;
      $display("FAIL busy_last_idx: got %0d required 2", b.ch_idx);
    end
  endtask

  task automatic test_abort_reset();
    for (int a = 0; a < 256; a++) mem[a] = DATA_W'($urandom);
    clear_obs();
    b.base_addr = 8'h20; b.ch_count = 9'd2; b.start = 1'b1;
    step();
    b.start = 1'b0;
    step();
    b.abort = 1'b1;
    step();
    b.abort = 1'b0;
    vectors++;
    if (b.busy !== 1'b0 || b.bias_read !== 1'b1 || b.bias_valid !== 1'b0 || b.mem_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: busy=%b read=%b valid=%b rd_en=%b required 0/1/0/0",
               b.busy, b.bias_read, b.bias_valid, b.mem_rd_en);
    end
    repeat (3) step();
    vectors++;
    if (addr_q.size() != 1 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL abort_quiet: reads=%0d pulses=%0d required 1/0", addr_q.size(), done_cnt);
    end
    b.base_addr = 8'h30; b.ch_count = 9'd2; b.start = 1'b1;
    step();
    b.start = 1'b0;
    repeat (2) step();
    vectors++;
    if (b.bias_read !== 1'b0 || b.bias_input !== mem[8'h30]) begin
      miscompares++;
      $display("FAIL abort_relayer_load: read=%b data=%h required 0/%h",
               b.bias_read, b.bias_input, mem[8'h30]);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (outs() !== RESET_OUTS) begin
      miscompares++;
      $display("FAIL midsim_reset: got %h expected %h", outs(), RESET_OUTS);
    end
    repeat (2) step();
    rst = 1'b0;
    step();
    vectors++;
    if (done_cnt != 0 || b.busy !== 1'b0 || b.bias_read !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset: pulses=%0d busy=%b read=%b required 0/0/1",
               done_cnt, b.busy, b.bias_read);
    end
  endtask

  task automatic test_random();
    bit to;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] ea;
    int gap;
    for (int l = 0; l < 10; l++) begin
      for (int a = 0; a < 256; a++) mem[a] = DATA_W'($urandom);
      base = ADDR_W'($urandom);
      cnt  = CNT_W'($urandom_range(1, 6));
      gap  = int'($urandom_range(0, 3));
      clear_obs();
      run_layer(base, cnt, gap, to);
      vectors++;
      if (to || addr_q.size() != int'(cnt) || load_q.size() != int'(cnt)
          || valid_q.size() != int'(cnt) || done_cnt != 1) begin
        miscompares++;
        $display("FAIL rand%0d_counts: timeout=%0d rd=%0d loads=%0d visits=%0d pulses=%0d required count %0d, 1 pulse",
                 l, to, addr_q.size(), load_q.size(), valid_q.size(), done_cnt, cnt);
        continue;
      end
      for (int i = 0; i < int'(cnt); i++) begin
        ea = base + ADDR_W'(i);
        vectors++;
        if (addr_q[i] !== ea || load_q[i] !== mem[ea] || hval_q[i] !== mem[ea]
            || valid_q[i] !== CNT_W'(i) || lat_q[i] != int'(LAT)) begin
          miscompares++;
          $display("FAIL rand%0d_ch%0d: addr=%h load=%h hold=%h idx=%0d lat=%0d required %h/%h/%h/%0d/%0d",
                   l, i, addr_q[i], load_q[i], hval_q[i], valid_q[i], lat_q[i],
                   ea, mem[ea], mem[ea], i, LAT);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_wrap();
    test_start_busy();
    test_abort_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
